// File: rtl/piso_serializer_if.sv
// Load-side handshake and serial-side outputs of the PISO serializer.
// The producer holds the master modport; the serializer holds the slave modport.
interface piso_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             sout;
  logic             sout_valid;
  logic             frame_start;
  logic             frame_done;
  logic             busy;

  modport master (
    output in_data, in_valid,
    input  in_ready, sout, sout_valid, frame_start, frame_done, busy
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, sout, sout_valid, frame_start, frame_done, busy
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with a one-word hold buffer for gapless frames,
// a programmable bit period, selectable bit order and an optional trailing parity bit.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter int DIV       = 1,
  parameter int MSB_FIRST = 0,
  parameter int PARITY    = 0
) (
  input  logic              clk,
  input  logic              reset,
  piso_serializer_if.slave  bus
);
  localparam int L  = WIDTH + ((PARITY != 0) ? 1 : 0);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(L);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [L-1:0]     shreg;
  logic [WIDTH-1:0] hold;
  logic             hold_full;
  logic [DW-1:0]    div_cnt;
  logic [BW-1:0]    bit_cnt;
  logic             sout_q, valid_q, start_q, done_q, busy_q;

  logic             accept, div_wrap, last_cyc, done_next;
  logic [L-1:0]     load_frame;

  // Frame is laid out in transmission order: bit 0 goes out first, parity last.
  function automatic logic [L-1:0] frame_of(input logic [WIDTH-1:0] d);
    logic [L-1:0] f;
    f = '0;
    for (int i = 0; i < WIDTH; i++)
      f[i] = (MSB_FIRST != 0) ? d[WIDTH-1-i] : d[i];
    if (PARITY != 0)
      f[L-1] = (^d) ^ (PARITY == 2);
    return f;
  endfunction

  assign bus.in_ready = !hold_full && !reset;
  assign accept       = bus.in_valid && bus.in_ready;
  assign div_wrap     = (div_cnt == DW'(DIV - 1));
  assign last_cyc     = div_wrap && (bit_cnt == BW'(L - 1));

  // Hold is only ever full in SHIFT, so in IDLE this always picks in_data;
  // at frame end an empty hold with a concurrent accept passes in_data straight through.
  assign load_frame   = frame_of(hold_full ? hold : bus.in_data);

  // Whether the cycle after this (non-final) one is the last cycle of the frame.
  assign done_next = div_wrap ? ((DIV == 1) && (bit_cnt == BW'(L - 2)))
                              : ((bit_cnt == BW'(L - 1)) && (div_cnt == DW'(DIV - 2)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      shreg     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      sout_q    <= 1'b0;
      valid_q   <= 1'b0;
      start_q   <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state   <= SHIFT;
            shreg   <= load_frame;
            div_cnt <= '0;
            bit_cnt <= '0;
            sout_q  <= load_frame[0];
            valid_q <= 1'b1;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
          end else begin
            sout_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        SHIFT: begin
          if (last_cyc) begin
            if (hold_full || accept) begin
              shreg     <= load_frame;
              hold_full <= 1'b0;
              div_cnt   <= '0;
              bit_cnt   <= '0;
              sout_q    <= load_frame[0];
              valid_q   <= 1'b1;
              start_q   <= 1'b1;
              busy_q    <= 1'b1;
            end else begin
              state   <= IDLE;
              sout_q  <= 1'b0;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
            end
          end else begin
            if (accept) begin
              hold      <= bus.in_data;
              hold_full <= 1'b1;
            end
            busy_q <= 1'b1;
            done_q <= done_next;
            if (div_wrap) begin
              div_cnt <= '0;
              bit_cnt <= bit_cnt + 1'b1;
              shreg   <= shreg >> 1;
              sout_q  <= shreg[1];
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sout        = sout_q;
  assign bus.sout_valid  = valid_q;
  assign bus.frame_start = start_q;
  assign bus.frame_done  = done_q;
  assign bus.busy        = busy_q;
endmodule

// File: tb/tb_piso_serializer.sv
// Four serializer configurations driven side by side; a frame-timeline model
// predicts every output cycle by cycle and a negedge monitor compares.
module tb_piso_serializer;
  localparam int N = 4;
  localparam int W = 8;

  function automatic int cfg_div(input int d);
    case (d)
      1: return 3;
      3: return 2;
      default: return 1;
    endcase
  endfunction
  function automatic int cfg_msb(input int d);
    return (d == 1 || d == 3) ? 1 : 0;
  endfunction
  function automatic int cfg_par(input int d);
    case (d)
      2: return 1;
      3: return 2;
      default: return 0;
    endcase
  endfunction
  function automatic int cfg_len(input int d);
    return W + ((cfg_par(d) != 0) ? 1 : 0);
  endfunction

  // i-th transmitted bit of word w, straight from the framing rules
  function automatic logic fbit(input int d, input logic [W-1:0] w, input int i);
    if (i < W) return (cfg_msb(d) != 0) ? w[W-1-i] : w[i];
    return (($countones(w) % 2) == 1) ^ (cfg_par(d) == 2);
  endfunction

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]   iv, rdy, so, sv, fs, fd, bz;
  logic [W-1:0]   idat [N];

  genvar g;
  generate
    for (g = 0; g < N; g++) begin : gd
      piso_serializer_if #(.WIDTH(W)) bus ();
      piso_serializer #(
        .WIDTH(W), .DIV(cfg_div(g)), .MSB_FIRST(cfg_msb(g)), .PARITY(cfg_par(g))
      ) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
      );
      assign bus.in_valid = iv[g];
      assign bus.in_data  = idat[g];
      assign rdy[g] = bus.in_ready;
      assign so[g]  = bus.sout;
      assign sv[g]  = bus.sout_valid;
      assign fs[g]  = bus.frame_start;
      assign fd[g]  = bus.frame_done;
      assign bz[g]  = bus.busy;
    end
  endgenerate

  // Each accepted word becomes a frame occupying cycles start..stop.
  typedef struct {
    logic [15:0] bits;
    int          acc;
    int          start;
    int          stop;
  } frame_t;

  frame_t     fr [N][512];
  int         fh [N];
  int         ft [N];
  int         last_end [N];
  logic [W-1:0] pend [N][256];
  int         ph [N];
  int         pt [N];
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  logic       gate_rand = 1'b0;

  logic       m_ev, m_eb, m_fs, m_fd, m_hold, m_busy;
  logic [5:0] m_got, m_exp;
  int         m_pos;
  frame_t     m_f;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cyc >= 1) begin
      for (int d = 0; d < N; d++) begin
        while (fh[d] != ft[d] && fr[d][fh[d] % 512].stop < cyc) fh[d]++;
        m_ev = 1'b0; m_eb = 1'b0; m_fs = 1'b0; m_fd = 1'b0; m_hold = 1'b0; m_busy = 1'b0;
        for (int k = fh[d]; k < ft[d]; k++) begin
          m_f = fr[d][k % 512];
          if (m_f.start <= cyc && cyc <= m_f.stop) begin
            m_pos = cyc - m_f.start;
            m_ev  = 1'b1;
            m_eb  = m_f.bits[m_pos / cfg_div(d)];
            m_fs  = (m_pos == 0);
            m_fd  = (cyc == m_f.stop);
          end
          if (m_f.acc < cyc && cyc < m_f.start) m_hold = 1'b1;
          if (m_f.acc < cyc && cyc <= m_f.stop) m_busy = 1'b1;
        end
        m_got = {sv[d], so[d], fs[d], fd[d], bz[d], rdy[d]};
        m_exp = {m_ev, m_eb, m_fs, m_fd, m_busy, !m_hold && !rst};
        total++;
        if (m_got !== m_exp) begin
          bad++;
          $display("FAIL dut%0d cyc=%0d {valid,sout,start,done,busy,ready} got=%b exp=%b",
                   d, cyc, m_got, m_exp);
        end
        if (rst) begin
          fh[d] = ft[d];
          last_end[d] = cyc;
        end else if (iv[d] && rdy[d]) begin
          m_f.bits  = '0;
          for (int i = 0; i < cfg_len(d); i++) m_f.bits[i] = fbit(d, idat[d], i);
          m_f.acc   = cyc;
          m_f.start = (cyc + 1 > last_end[d] + 1) ? cyc + 1 : last_end[d] + 1;
          m_f.stop  = m_f.start + cfg_len(d) * cfg_div(d) - 1;
          last_end[d] = m_f.stop;
          fr[d][ft[d] % 512] = m_f;
          ft[d]++;
          ph[d]++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    for (int d = 0; d < N; d++) begin
      iv[d]   = (ph[d] != pt[d]) && (!gate_rand || ($urandom_range(0, 2) != 0));
      idat[d] = iv[d] ? pend[d][ph[d] % 256] : W'($urandom);
    end
  endtask

  task automatic push(input int d, input logic [W-1:0] w);
    pend[d][pt[d] % 256] = w;
    pt[d]++;
  endtask

  task automatic push_all(input logic [W-1:0] w);
    for (int d = 0; d < N; d++) push(d, w);
  endtask

  function automatic logic all_drained();
    for (int d = 0; d < N; d++)
      if (ph[d] != pt[d]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (n < budget && !(all_drained() && iv == '0 && bz == '0)) begin
      step();
      n++;
    end
    if (n >= budget) begin
      total++;
      bad++;
      $display("FAIL idle_timeout got=busy(%b) exp=idle within %0d cycles", bz, budget);
    end
  endtask

  initial begin
    iv = '0;
    for (int d = 0; d < N; d++) begin
      idat[d] = '0; fh[d] = 0; ft[d] = 0; ph[d] = 0; pt[d] = 0; last_end[d] = 0;
    end
    repeat (3) step();
    rst = 1'b0;
    step();

    // single frames, back-to-back pair, bit order / period, parity cases
    push_all(8'hA5);                   wait_idle(200);
    push_all(8'h0F); push_all(8'hF0);  wait_idle(200);
    push_all(8'hC3);                   wait_idle(200);
    push_all(8'h07);                   wait_idle(200);
    push_all(8'h00);                   wait_idle(200);
    push_all(8'h11); push_all(8'h22); push_all(8'h33); wait_idle(400);

    // random valid gaps with backpressure
    gate_rand = 1'b1;
    for (int k = 0; k < 100; k++)
      for (int d = 0; d < N; d++) push(d, W'($urandom));
    wait_idle(20000);
    gate_rand = 1'b0;

    // reset mid-frame with the hold buffer occupied
    push_all(8'h3C); push_all(8'h96); push_all(8'h69);
    repeat (11) step();
    rst = 1'b1;
    iv  = '0;
    for (int d = 0; d < N; d++) ph[d] = pt[d];
    step();
    rst = 1'b0;
    step();
    push_all(8'h5A);
    wait_idle(200);
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parametrised parallel-in/serial-out serializer with a valid/ready load handshake, a one-word holding buffer for gapless back-to-back frames, a programmable bit period, selectable bit order and an optional appended parity bit. It generalises the team's basic PISO shift register and sits between a word-wide producer (FIFO or register bank) and a single-wire serial link or bit-level line encoder.

## Interface
- WIDTH, 8, data bits per word (≥2)
- DIV, 1, clock cycles per serial bit (≥1)
- MSB_FIRST, 0, 0 = bit 0 sent first; 1 = bit WIDTH-1 sent first
- PARITY, 0, 0 = none; 1 = even; 2 = odd (one bit appended after the data)
- clk  input  1  clock; all logic on rising edge
- reset  input  1  reset, synchronous, active-high
- in_data  input  WIDTH  parallel word
- in_valid  input  1  producer has a word on in_data
- in_ready  output  1  block accepts a word this cycle
- sout  output  1  serial data
- sout_valid  output  1  sout carries a frame bit this cycle
- frame_start  output  1  pulse: first cycle of the first bit of a frame
- frame_done  output  1  pulse: last cycle of the last bit of a frame
- busy  output  1  shifter active or holding buffer occupied

## Operation
- Frame length L = WIDTH + (PARITY != 0). Each bit is driven for exactly DIV cycles.
- Storage: shifter (WIDTH bits plus parity bit), holding buffer (WIDTH bits plus full flag), div counter (0..DIV-1) and bit counter (0..L-1).
- Handshake: a word transfers on any edge where in_valid && in_ready. in_ready = !hold_full && !reset. in_data is not sampled otherwise.
- FSM states:
  - IDLE: shifter empty.
    - On accept, the word loads directly into the shifter, bypassing the hold buffer, and the FSM moves to SHIFT.
  - SHIFT: frame in progress.
    - An accept stores the word in the hold buffer.
    - At the end of the last bit (bit counter = L-1 and div counter = DIV-1):
      - If hold is full, the shifter loads from hold, hold empties, and the FSM stays in SHIFT.
      - If hold is empty, the FSM returns to IDLE.
- Parity: computed when the word is loaded into the shifter. Even parity is the XOR of all data bits; odd parity is its complement. The parity bit is always sent last, independent of MSB_FIRST.
- sout = current bit when sout_valid, else 0.
- busy = (state == SHIFT) || hold_full.
- Simultaneous events:
  - Hold drain at end of frame while in_valid is high: in_ready was 0 that cycle, so there is no accept. in_ready rises the next cycle.
  - Accept in the final bit cycle of a frame with hold empty: the word goes to hold and is loaded at the same edge. The net effect is a direct pass-through, with hold empty afterwards.
- Reset (including mid-frame):
  - The frame aborts and the hold contents are discarded.
  - Both counters clear, the FSM goes to IDLE and all outputs take their reset values.
  - There is no partial-frame completion and no frame_done pulse.

## Timing
- Reset values: sout 0, sout_valid 0, frame_start 0, frame_done 0, busy 0, in_ready 0 while reset is high, then 1 in the first cycle after reset deasserts.
- All outputs are registered except in_ready, which is combinational from hold_full and reset.
- Latency: for a word accepted at the edge ending cycle T while in IDLE, the first bit appears on sout in cycles T+1..T+DIV, with frame_start high in cycle T+1.
- Frame duration: L·DIV cycles. frame_done is high in cycle T+L·DIV.
- Back-to-back: with hold full at the end of a frame, the next frame_start is in the cycle directly after frame_done. sout_valid has no gap.
- Throughput: one word per L·DIV cycles sustained. At most two words are in flight: one in the shifter, one in hold.

## Test plan
- WIDTH=8, DIV=1, LSB first, no parity; accept 0xA5 at T → sout = 1,0,1,0,0,1,0,1 in cycles T+1..T+8; frame_start at T+1; frame_done at T+8; sout_valid then drops, busy drops, FSM returns to IDLE.
- in_valid held high with 0x0F then 0xF0 → 16 contiguous valid bits 1,1,1,1,0,0,0,0,0,0,0,0,1,1,1,1; second frame_start immediately follows the first frame_done; in_ready low while hold is full.
- MSB_FIRST=1, DIV=3; word 0xC3 → each bit stable for 3 cycles, order 1,1,0,0,0,0,1,1; frame_done in the 24th cycle.
- PARITY=1 with 0x07 → 9 bits, last bit 1. PARITY=2 with 0x07 → last bit 0. PARITY=1 with 0x00 → last bit 0.
- Backpressure: third word presented while the shifter and hold are both full → in_ready stays 0 until the edge where hold drains; the word is accepted exactly once; no word is lost or duplicated across 100 random in_valid patterns, checked against a scoreboard.
- Assert reset in the 4th bit of a frame with hold full → the next cycle shows sout_valid 0, busy 0, no frame_done, hold discarded. in_ready returns to 1 after reset deasserts, and a new word then serializes correctly.
